// File: rtl/fetch_pkg.sv
// fetch_pkg: shared fetch-side types and constants.
//   XLEN          - machine word / address width
//   fetch_state_t - fetch FSM states (request, wait for data, drop stale data)
package fetch_pkg;
    localparam int XLEN = 64;
    typedef enum logic [1:0] {S_REQ, S_WAIT, S_DROP} fetch_state_t;
endpackage

// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory read bus between fetch unit and memory.
//   req_valid/req_ready/req_addr - read request handshake (master drives valid/addr)
//   resp_valid/resp_data         - one-cycle response pulse, never back-pressured
interface instruction_fetch_unit_if;
    import fetch_pkg::*;
    logic            req_valid;
    logic            req_ready;
    logic [XLEN-1:0] req_addr;
    logic            resp_valid;
    logic [XLEN-1:0] resp_data;
    modport master (output req_valid, req_addr, input req_ready, resp_valid, resp_data);
    modport slave  (input req_valid, req_addr, output req_ready, resp_valid, resp_data);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner and single-outstanding instruction fetcher feeding IF/ID.
//   clk, reset                        - clock, async active-high reset
//   imem                              - instruction-memory read bus (master side)
//   redirect_valid, redirect_target   - retarget PC from later stages, highest priority
//   id_stall                          - downstream hold; output buffer frozen while valid
//   fetch_valid/address/instruction   - output buffer driving the IF/ID register inputs
module instruction_fetch_unit import fetch_pkg::*; #(
    parameter logic [XLEN-1:0] RESET_PC = 64'h0,
    parameter logic [XLEN-1:0] PC_STEP  = 64'd4
) (
    input  logic                      clk,
    input  logic                      reset,
    instruction_fetch_unit_if.master  imem,
    input  logic                      redirect_valid,
    input  logic [XLEN-1:0]           redirect_target,
    input  logic                      id_stall,
    output logic                      fetch_valid,
    output logic [XLEN-1:0]           fetch_address,
    output logic [XLEN-1:0]           fetch_instruction
);
    fetch_state_t    state, state_next;
    logic [XLEN-1:0] pc, pc_next;
    logic            out_free, handshake, capture, fetch_valid_next;

    // A request is only issued when its result is guaranteed a free buffer slot.
    assign out_free       = !fetch_valid || !id_stall;
    assign imem.req_valid = (state == S_REQ) && out_free && !reset;
    assign imem.req_addr  = pc;
    assign handshake      = imem.req_valid && imem.req_ready;
    // A response coinciding with a redirect belongs to the old path and is dropped.
    assign capture        = (state == S_WAIT) && imem.resp_valid && !redirect_valid;

    always_comb begin
        state_next = state;
        case (state)
            S_REQ:   state_next = handshake ? (redirect_valid ? S_DROP : S_WAIT) : S_REQ;
            S_WAIT:  state_next = imem.resp_valid ? S_REQ : (redirect_valid ? S_DROP : S_WAIT);
            S_DROP:  state_next = imem.resp_valid ? S_REQ : S_DROP;
            default: state_next = S_REQ;
        endcase
        pc_next          = redirect_valid ? redirect_target : capture ? pc + PC_STEP : pc;
        fetch_valid_next = redirect_valid ? 1'b0 : capture ? 1'b1 : fetch_valid && id_stall;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= S_REQ;
            pc                <= RESET_PC;
            fetch_valid       <= 1'b0;
            fetch_address     <= '0;
            fetch_instruction <= '0;
        end else begin
            state       <= state_next;
            pc          <= pc_next;
            fetch_valid <= fetch_valid_next;
            if (capture) begin
                fetch_address     <= pc;
                fetch_instruction <= imem.resp_data;
            end
        end
    end
endmodule
